// File: rtl/apv_frame_processor_pkg.sv
// Shared constants for the APV frame processor.
// Holds the output word tags, frame geometry, the marker sample value,
// the output word field positions, the datapath widths and a helper that
// packs an output word from its fields.
package apv_frame_processor_pkg;

  localparam int APV_N_CHANNELS = 128;
  localparam int DATA_W         = 13;
  localparam int BASE_W         = 12;
  localparam int OUT_W          = 24;

  // Output word tags
  localparam logic [1:0] TAG_HDR = 2'b00;
  localparam logic [1:0] TAG_SMP = 2'b01;
  localparam logic [1:0] TAG_TRL = 2'b10;

  // A sample with this raw value is forwarded untouched and never dropped.
  localparam logic [DATA_W-1:0] MARKER_WORD = 13'h0FFF;

  // Output word field positions: [23:22] tag, [21:14] aux, [13] 0, [12:0] value
  localparam int TAG_MSB = 23;
  localparam int TAG_LSB = 22;
  localparam int AUX_MSB = 21;
  localparam int AUX_LSB = 14;
  localparam int PAD_BIT = 13;
  localparam int VAL_MSB = 12;
  localparam int VAL_LSB = 0;

  function automatic logic [OUT_W-1:0] pack_word(input logic [1:0]        tag,
                                                 input logic [7:0]        aux,
                                                 input logic [DATA_W-1:0] value);
    logic [OUT_W-1:0] w;
    w                  = '0;
    w[TAG_MSB:TAG_LSB] = tag;
    w[AUX_MSB:AUX_LSB] = aux;
    w[PAD_BIT]         = 1'b0;
    w[VAL_MSB:VAL_LSB] = value;
    return w;
  endfunction

endpackage

// File: rtl/apv_frame_processor_out_buffer.sv
// apv_out_buffer: two-entry synchronous FIFO that decouples the frame
// datapath from the event builder's ready signal.
// Ports:
//   CLK, RST    clock, asynchronous active-high reset (empties the buffer)
//   PUSH        write PUSH_DATA at the tail
//   PUSH_DATA   24-bit tagged word
//   POP         drop the head entry (driven as OUT_VALID & OUT_READY)
//   HEAD_DATA   head entry, held stable until popped
//   HEAD_VALID  buffer is not empty
//   OCCUPANCY   number of stored entries (0..2)
module apv_out_buffer
  import apv_frame_processor_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             PUSH,
  input  logic [OUT_W-1:0] PUSH_DATA,
  input  logic             POP,
  output logic [OUT_W-1:0] HEAD_DATA,
  output logic             HEAD_VALID,
  output logic [1:0]       OCCUPANCY
);

  logic [OUT_W-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (PUSH) begin
        mem_q[wr_ptr_q] <= PUSH_DATA;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (POP) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, PUSH} - {1'b0, POP};
    end
  end

  assign HEAD_DATA  = mem_q[rd_ptr_q];
  assign HEAD_VALID = (count_q != 2'd0);
  assign OCCUPANCY  = count_q;

endmodule

// File: rtl/apv_frame_processor.sv
// apv_frame_processor: downstream stage of one APV readout channel.
// Pops a complete frame (header, N_CHANNELS samples, trailer) from the data
// FIFO plus one baseline word per frame, subtracts the baseline, optionally
// zero-suppresses, and emits tagged 24-bit words.
//
// Output handshake: a word transfers on a rising edge where OUT_VALID and
// OUT_READY are both 1; while OUT_VALID = 1 and OUT_READY = 0 the word on
// OUT_DATA is held unchanged, and OUT_VALID never drops without a transfer.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   ENABLE            permits starting a new frame
//   ZS_ENABLE         drop samples at or below THRESHOLD
//   BASELINE_ENABLE   0 = subtract 0 instead of MEAN
//   THRESHOLD         zero-suppression threshold (unsigned)
//   FIFO_DATA/EMPTY   data FIFO q (valid 1 cycle after FIFO_RD) and empty
//   FIFO_RD           data FIFO read request
//   MEAN              baseline FIFO q (valid 1 cycle after RD_NEXT_MEAN)
//   ONE_MORE_EVENT    a complete frame is stored
//   RD_NEXT_MEAN      baseline FIFO read request
//   OUT_DATA/VALID    tagged output word, valid
//   OUT_READY         consumer accepts the word
//   BUSY              state machine not in IDLE
//   FRAME_ERROR       sticky bad-header flag, CLEAR_ERROR clears it
//   DBG_STATE         current state code, for observation only
module apv_frame_processor
  import apv_frame_processor_pkg::*;
#(
  parameter int N_CHANNELS = APV_N_CHANNELS,
  parameter int OUT_DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              ZS_ENABLE,
  input  logic              BASELINE_ENABLE,
  input  logic [BASE_W-1:0] THRESHOLD,
  input  logic [DATA_W-1:0] FIFO_DATA,
  input  logic              FIFO_EMPTY,
  output logic              FIFO_RD,
  input  logic [BASE_W-1:0] MEAN,
  input  logic              ONE_MORE_EVENT,
  output logic              RD_NEXT_MEAN,
  output logic [OUT_W-1:0]  OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              FRAME_ERROR,
  input  logic              CLEAR_ERROR,
  output logic [2:0]        DBG_STATE
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MEAN = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_SMP  = 3'd3;
  localparam logic [2:0] ST_TRL  = 3'd4;

  localparam logic [6:0] LAST_CHAN = 7'(N_CHANNELS - 1);
  localparam logic [7:0] KEPT_MAX  = 8'(N_CHANNELS);

  logic [2:0]        state_q;
  logic [BASE_W-1:0] base_q;
  logic [BASE_W-1:0] thr_q;
  logic              zs_q;
  logic [6:0]        chan_q;
  logic [7:0]        kept_q;
  logic              frame_error_q;

  // One read is in flight for a cycle: its kind and channel travel with it.
  logic              rd_vld_q;
  logic [1:0]        rd_tag_q;
  logic [6:0]        rd_chan_q;

  logic              start;
  logic              in_frame;
  logic              rd_issue;
  logic [1:0]        rd_tag;
  logic              pop;
  logic              push;
  logic [OUT_W-1:0]  push_data;
  logic [1:0]        occupancy;
  logic [2:0]        committed;
  logic signed [13:0] diff;
  logic [12:0]       sat;
  logic              is_marker;
  logic              keep;
  logic              hdr_bad;
  logic              kept_inc;

  // ---------------------------------------------------------------- control
  // RST gates the start request so no baseline pop escapes during reset.
  assign start    = (state_q == ST_IDLE) & ENABLE & ONE_MORE_EVENT & ~FIFO_EMPTY & ~RST;
  assign in_frame = (state_q == ST_HDR) | (state_q == ST_SMP) | (state_q == ST_TRL);
  assign pop      = OUT_VALID & OUT_READY;

  // Slots already spoken for: stored words plus the word still in flight,
  // minus the word leaving this cycle. A read is only issued when its word
  // is guaranteed a slot, so the buffer can never overflow.
  assign committed = {1'b0, occupancy} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign rd_issue  = in_frame & ~FIFO_EMPTY & (committed < 3'(OUT_DEPTH));

  always_comb begin
    rd_tag = TAG_TRL;
    case (state_q)
      ST_HDR:  rd_tag = TAG_HDR;
      ST_SMP:  rd_tag = TAG_SMP;
      default: rd_tag = TAG_TRL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      thr_q   <= '0;
      zs_q    <= 1'b0;
      chan_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_q <= ST_MEAN;
        ST_MEAN: begin
          base_q  <= BASELINE_ENABLE ? MEAN : '0;
          thr_q   <= THRESHOLD;
          zs_q    <= ZS_ENABLE;
          chan_q  <= '0;
          state_q <= ST_HDR;
        end
        ST_HDR: if (rd_issue) state_q <= ST_SMP;
        ST_SMP: if (rd_issue) begin
          chan_q <= chan_q + 7'd1;
          if (chan_q == LAST_CHAN) state_q <= ST_TRL;
        end
        ST_TRL: if (rd_issue) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_vld_q  <= 1'b0;
      rd_tag_q  <= TAG_HDR;
      rd_chan_q <= '0;
    end else begin
      rd_vld_q  <= rd_issue;
      rd_tag_q  <= rd_tag;
      rd_chan_q <= chan_q;
    end
  end

  // --------------------------------------------------------------- datapath
  // Unsigned 13-bit sample minus unsigned 12-bit baseline fits in 14 bits
  // signed; the result is clamped to the 13-bit signed output range.
  always_comb begin
    diff = $signed({1'b0, FIFO_DATA}) - $signed({2'b00, base_q});
    if (diff > 14'sd4095)       sat = 13'h0FFF;
    else if (diff < -14'sd4096) sat = 13'h1000;
    else                        sat = diff[12:0];
  end

  assign is_marker = (FIFO_DATA == MARKER_WORD);
  assign keep      = is_marker | ~zs_q |
                     ($signed({sat[12], sat}) > $signed({2'b00, thr_q}));

  always_comb begin
    push_data = '0;
    case (rd_tag_q)
      TAG_HDR: push_data = pack_word(TAG_HDR, 8'h00, {1'b0, FIFO_DATA[11:0]});
      TAG_SMP: push_data = pack_word(TAG_SMP, {1'b0, rd_chan_q},
                                     is_marker ? MARKER_WORD : sat);
      default: push_data = pack_word(TAG_TRL, kept_q, {1'b0, FIFO_DATA[11:0]});
    endcase
  end

  assign push     = rd_vld_q & ((rd_tag_q != TAG_SMP) | keep);
  assign hdr_bad  = rd_vld_q & (rd_tag_q == TAG_HDR) & (FIFO_DATA[11:9] != 3'b111);
  assign kept_inc = rd_vld_q & (rd_tag_q == TAG_SMP) & keep & (kept_q != KEPT_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kept_q <= '0;
    end else if (state_q == ST_MEAN) begin
      kept_q <= '0;
    end else if (kept_inc) begin
      kept_q <= kept_q + 8'd1;
    end
  end

  // A new bad header outranks a clear in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              frame_error_q <= 1'b0;
    else if (hdr_bad)     frame_error_q <= 1'b1;
    else if (CLEAR_ERROR) frame_error_q <= 1'b0;
  end

  apv_out_buffer u_out_buffer (
    .CLK        (CLK),
    .RST        (RST),
    .PUSH       (push),
    .PUSH_DATA  (push_data),
    .POP        (pop),
    .HEAD_DATA  (OUT_DATA),
    .HEAD_VALID (OUT_VALID),
    .OCCUPANCY  (occupancy)
  );

  assign FIFO_RD      = rd_issue;
  assign RD_NEXT_MEAN = start;
  assign BUSY         = (state_q != ST_IDLE);
  assign FRAME_ERROR  = frame_error_q;
  assign DBG_STATE    = state_q;

endmodule
